// File: rtl/packet_inject_sched_pkg.sv
// Shared definitions for the packet injection scheduler: FSM encoding,
// flow_ctrl field offsets and width helpers.
package packet_inject_sched_pkg;

  function automatic int clogb(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? clogb(n) : 1;
  endfunction

  function automatic int credit_width(input int per_vc);
    return clogb(per_vc + 1);
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } pis_state_t;

  // flow_ctrl layout: bit 0 = credit valid, bits above = returned VC index.
  localparam int FC_VALID_POS = 0;
  localparam int FC_VC_LSB    = 1;

endpackage

// File: rtl/packet_inject_sched_credit_tracker.sv
// Per-VC downstream credit counters with availability vector and sticky
// overflow error.
module pis_credit_tracker
  import packet_inject_sched_pkg::*;
#(
  parameter int num_vcs            = 8,
  parameter int buffer_size_per_vc = 8,
  localparam int vc_idx_width      = idx_width(num_vcs),
  localparam int cnt_width         = credit_width(buffer_size_per_vc)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dec_valid,
  input  logic [vc_idx_width-1:0] dec_vc,
  input  logic                    inc_valid,
  input  logic [vc_idx_width-1:0] inc_vc,
  output logic [num_vcs-1:0]      avail_ovc,
  output logic                    error
);

  localparam logic [cnt_width-1:0] full = cnt_width'(buffer_size_per_vc);

  logic [cnt_width-1:0] credit [num_vcs];
  logic [num_vcs-1:0]   dec_hit;
  logic [num_vcs-1:0]   inc_hit;
  logic [num_vcs-1:0]   overflow;

  always_comb begin
    for (int v = 0; v < num_vcs; v++) begin
      dec_hit[v]   = dec_valid && (dec_vc == vc_idx_width'(v));
      inc_hit[v]   = inc_valid && (inc_vc == vc_idx_width'(v));
      avail_ovc[v] = (credit[v] != '0);
      overflow[v]  = inc_hit[v] && !dec_hit[v] && (credit[v] == full);
    end
  end

  // A send and a return on the same VC cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < num_vcs; v++) credit[v] <= full;
      error <= 1'b0;
    end else begin
      for (int v = 0; v < num_vcs; v++) begin
        if (inc_hit[v] && !dec_hit[v] && credit[v] != full)
          credit[v] <= credit[v] + 1'b1;
        else if (dec_hit[v] && !inc_hit[v])
          credit[v] <= credit[v] - 1'b1;
      end
      error <= error | (|overflow);
    end
  end

endmodule

// File: rtl/packet_inject_sched.sv
// Injection-side scheduler: RR source and VC selection, credit gating and
// head..tail flit sequencing. Define PIS_STATS_EN for pkt/flit counters.
module packet_inject_sched
  import packet_inject_sched_pkg::*;
#(
  parameter int num_srcs            = 4,
  parameter int num_vcs             = 8,
  parameter int buffer_size         = 64,
  parameter int max_payload_length  = 4,
  parameter int min_payload_length  = 1,
  localparam int vc_idx_width         = idx_width(num_vcs),
  localparam int src_idx_width        = idx_width(num_srcs),
  localparam int buffer_size_per_vc   = buffer_size / num_vcs,
  localparam int payload_length_width = idx_width(max_payload_length - min_payload_length + 1),
  localparam int remaining_width      = clogb(max_payload_length + 2)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [num_srcs-1:0]                  src_req,
  input  logic [num_srcs*payload_length_width-1:0] src_len,
  output logic [num_srcs-1:0]                  src_gnt,
  output logic [num_srcs-1:0]                  src_pop,
  output logic                                 flit_valid,
  output logic                                 flit_head,
  output logic                                 flit_tail,
  output logic [num_vcs-1:0]                   flit_sel_ovc,
  input  logic [vc_idx_width:0]                flow_ctrl,
  output logic                                 busy,
  output logic                                 error
`ifdef PIS_STATS_EN
  ,
  output logic [31:0]                          pkt_count,
  output logic [31:0]                          flit_count
`endif
);

  pis_state_t                      state;
  logic [src_idx_width-1:0]        src_q, src_ptr, win_src;
  logic [vc_idx_width-1:0]         vc_q, vc_ptr, win_vc;
  logic [remaining_width-1:0]      remaining;
  logic [payload_length_width-1:0] win_code;
  logic [num_vcs-1:0]              avail_ovc;
  logic                            head_pending, src_found, vc_found, grant, send;

  // Round-robin searches start at the pointer and take the first hit.
  always_comb begin
    win_src   = '0;
    src_found = 1'b0;
    for (int i = 0; i < num_srcs; i++) begin
      if (!src_found && src_req[(int'(src_ptr) + i) % num_srcs]) begin
        src_found = 1'b1;
        win_src   = src_idx_width'((int'(src_ptr) + i) % num_srcs);
      end
    end
    win_vc   = '0;
    vc_found = 1'b0;
    for (int i = 0; i < num_vcs; i++) begin
      if (!vc_found && avail_ovc[(int'(vc_ptr) + i) % num_vcs]) begin
        vc_found = 1'b1;
        win_vc   = vc_idx_width'((int'(vc_ptr) + i) % num_vcs);
      end
    end
  end

  assign win_code     = src_len[int'(win_src)*payload_length_width +: payload_length_width];
  assign grant        = (state == ST_IDLE) && src_found && vc_found;
  assign send         = (state == ST_SEND) && avail_ovc[vc_q];
  assign src_gnt      = grant ? (num_srcs'(1) << win_src) : '0;
  assign src_pop      = send ? (num_srcs'(1) << src_q) : '0;
  assign flit_valid   = send;
  assign flit_head    = send && head_pending;
  assign flit_tail    = send && (remaining == remaining_width'(1));
  assign flit_sel_ovc = send ? (num_vcs'(1) << vc_q) : '0;
  assign busy         = (state == ST_SEND);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      src_q        <= '0;
      vc_q         <= '0;
      remaining    <= '0;
      head_pending <= 1'b0;
      src_ptr      <= '0;
      vc_ptr       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            state        <= ST_SEND;
            src_q        <= win_src;
            vc_q         <= win_vc;
            remaining    <= remaining_width'(win_code) + remaining_width'(min_payload_length + 1);
            head_pending <= 1'b1;
            src_ptr      <= (int'(win_src) == num_srcs - 1) ? '0 : win_src + 1'b1;
            vc_ptr       <= (int'(win_vc) == num_vcs - 1) ? '0 : win_vc + 1'b1;
          end
        end
        ST_SEND: begin
          if (send) begin
            remaining    <= remaining - 1'b1;
            head_pending <= 1'b0;
            if (remaining == remaining_width'(1)) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pis_credit_tracker #(
    .num_vcs            (num_vcs),
    .buffer_size_per_vc (buffer_size_per_vc)
  ) u_credit (
    .clk       (clk),
    .reset     (reset),
    .dec_valid (send),
    .dec_vc    (vc_q),
    .inc_valid (flow_ctrl[FC_VALID_POS]),
    .inc_vc    (flow_ctrl[FC_VC_LSB +: vc_idx_width]),
    .avail_ovc (avail_ovc),
    .error     (error)
  );

`ifdef PIS_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count  <= '0;
      flit_count <= '0;
    end else begin
      if (flit_valid) flit_count <= flit_count + 32'd1;
      if (flit_valid && flit_tail) pkt_count <= pkt_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_packet_inject_sched.sv
// Bench for packet_inject_sched: directed scenarios plus a randomized run
// against a packet-level reference model.
module tb_packet_inject_sched;
  localparam int NS = 4, NV = 8, PLW = 2, VW = 3, PER_VC = 8, MINP = 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [NS-1:0]   src_req;
  logic [NS*PLW-1:0] src_len;
  logic [NS-1:0]   src_gnt, src_pop;
  logic            flit_valid, flit_head, flit_tail;
  logic [NV-1:0]   flit_sel_ovc;
  logic [VW:0]     flow_ctrl;
  logic            busy, error;
`ifdef PIS_STATS_EN
  logic [31:0]     pkt_count, flit_count;
`endif

  int checks = 0;
  int passes = 0;

  packet_inject_sched dut (
    .clk          (clk),
    .reset        (reset),
    .src_req      (src_req),
    .src_len      (src_len),
    .src_gnt      (src_gnt),
    .src_pop      (src_pop),
    .flit_valid   (flit_valid),
    .flit_head    (flit_head),
    .flit_tail    (flit_tail),
    .flit_sel_ovc (flit_sel_ovc),
    .flow_ctrl    (flow_ctrl),
    .busy         (busy),
    .error        (error)
`ifdef PIS_STATS_EN
    ,
    .pkt_count    (pkt_count),
    .flit_count   (flit_count)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: credits per VC, current packet, last winners
  int          m_cred [NV];
  bit          m_err, m_inpkt, m_first;
  int          m_src, m_vc, m_left, m_last_src, m_last_vc;
  logic [31:0] m_flits, m_pkts;

  logic [NS-1:0] e_gnt, e_pop;
  logic          e_valid, e_head, e_tail, e_busy, e_err;
  logic [NV-1:0] e_ovc;
  int            e_gsrc, e_gvc;
  logic [20:0]   exp_vec;
  logic [20:0]   obs;

  assign obs = {src_gnt, src_pop, flit_valid, flit_head, flit_tail, flit_sel_ovc, busy, error};

  task automatic model_reset();
    for (int v = 0; v < NV; v++) m_cred[v] = PER_VC;
    m_err = 0; m_inpkt = 0; m_first = 0;
    m_src = 0; m_vc = 0; m_left = 0;
    m_last_src = NS - 1; m_last_vc = NV - 1;
    m_flits = 0; m_pkts = 0;
  endtask

  task automatic model_eval();
    e_gnt = '0; e_pop = '0; e_valid = 0; e_head = 0; e_tail = 0; e_ovc = '0;
    e_gsrc = -1; e_gvc = -1;
    e_busy = m_inpkt; e_err = m_err;
    if (!m_inpkt) begin
      for (int k = 1; k <= NS; k++)
        if (e_gsrc < 0 && src_req[(m_last_src + k) % NS]) e_gsrc = (m_last_src + k) % NS;
      for (int k = 1; k <= NV; k++)
        if (e_gvc < 0 && m_cred[(m_last_vc + k) % NV] > 0) e_gvc = (m_last_vc + k) % NV;
      if (e_gsrc >= 0 && e_gvc >= 0) e_gnt[e_gsrc] = 1'b1;
    end else if (m_cred[m_vc] > 0) begin
      e_valid = 1; e_pop[m_src] = 1'b1; e_head = m_first;
      e_tail = (m_left == 1); e_ovc[m_vc] = 1'b1;
    end
    exp_vec = {e_gnt, e_pop, e_valid, e_head, e_tail, e_ovc, e_busy, e_err};
  endtask

  task automatic model_advance();
    int inc_vc, dec_vc;
    if (reset) begin
      model_reset();
      return;
    end
    dec_vc = -1;
    inc_vc = flow_ctrl[0] ? int'(flow_ctrl[VW:1]) : -1;
    if (e_valid) begin
      dec_vc = m_vc; m_left--; m_first = 0; m_flits++;
      if (m_left == 0) begin m_inpkt = 0; m_pkts++; end
    end
    if (|e_gnt) begin
      m_inpkt = 1; m_src = e_gsrc; m_vc = e_gvc; m_first = 1;
      m_left = int'(src_len[e_gsrc*PLW +: PLW]) + MINP + 1;
      m_last_src = e_gsrc; m_last_vc = e_gvc;
    end
    if (inc_vc != dec_vc) begin
      if (dec_vc >= 0) m_cred[dec_vc]--;
      if (inc_vc >= 0) begin
        if (m_cred[inc_vc] == PER_VC) m_err = 1;
        else m_cred[inc_vc]++;
      end
    end
  endtask

  // driver tasks: sample at negedge, advance after posedge
  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic do_reset();
    reset = 1; src_req = '0; src_len = '0; flow_ctrl = '0;
    repeat (2) begin sample(); advance(); end
    reset = 0;
  endtask

  task automatic run_packets(input int n, input int code);
    int got, budget;
    got = 0;
    budget = n * (code + 5) + 10;
    src_len = {NS{2'(code)}};
    src_req = (n > 0) ? 4'b0001 : 4'b0000;
    while ((got < n || m_inpkt) && budget > 0) begin
      sample();
      if (obs !== exp_vec) $display("FAIL run_packets got=%h exp=%h", obs, exp_vec); else passes++;
      checks++;
      if (|e_gnt) got++;
      advance();
      if (got >= n) src_req = '0;
      budget--;
    end
    if (budget == 0 || busy !== 1'b0) $display("FAIL run_packets_done busy=%b budget=%0d exp busy=0", busy, budget);
    else passes++;
    checks++;
  endtask

  task automatic test_reset();
    do_reset();
    sample();
    if (obs !== 21'd0) $display("FAIL reset_outputs got=%h exp=0", obs); else passes++;
    checks++;
    if (obs !== exp_vec) $display("FAIL reset_model got=%h exp=%h", obs, exp_vec); else passes++;
    checks++;
    advance();
  endtask

  task automatic test_single_packet();
    do_reset();
    src_len = {NS{2'd2}};
    src_req = 4'b0001;
    sample();
    if (src_gnt !== 4'b0001) $display("FAIL single_gnt got=%b exp=0001", src_gnt); else passes++;
    checks++;
    advance();
    src_req = '0;
    for (int k = 0; k < 4; k++) begin
      sample();
      if ({flit_valid, flit_head, flit_tail, flit_sel_ovc, src_pop} !== {1'b1, k == 0, k == 3, 8'h01, 4'b0001})
        $display("FAIL single_flit%0d got=%b%b%b %h %b exp=1%b%b 01 0001", k, flit_valid, flit_head,
                 flit_tail, flit_sel_ovc, src_pop, k == 0, k == 3);
      else passes++;
      checks++;
      if (obs !== exp_vec) $display("FAIL single_model got=%h exp=%h", obs, exp_vec); else passes++;
      checks++;
      advance();
    end
    sample();
    if (flit_valid !== 1'b0 || busy !== 1'b0) $display("FAIL single_end valid=%b busy=%b exp 0 0", flit_valid, busy);
    else passes++;
    checks++;
    advance();
  endtask

  task automatic test_alternate();
    logic [NS-1:0] exp_q [$];
    logic [NV-1:0] ovc_q [$];
    logic [NS-1:0] eg;
    logic [NV-1:0] eo;
    int last_tail;
    do_reset();
    exp_q = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    ovc_q = '{8'h01, 8'h02, 8'h04, 8'h08};
    src_len = NS*PLW'($urandom);
    src_req = 4'b0101;
    last_tail = -1;
    for (int cyc = 0; cyc < 60 && ovc_q.size() > 0; cyc++) begin
      sample();
      if (obs !== exp_vec) $display("FAIL alt_model got=%h exp=%h", obs, exp_vec); else passes++;
      checks++;
      if (src_gnt !== 4'b0000 && exp_q.size() > 0) begin
        eg = exp_q.pop_front();
        if (src_gnt !== eg) $display("FAIL alt_gnt got=%b exp=%b", src_gnt, eg); else passes++;
        checks++;
      end
      if (flit_valid === 1'b1 && flit_head === 1'b1) begin
        eo = ovc_q.pop_front();
        if (flit_sel_ovc !== eo) $display("FAIL alt_ovc got=%h exp=%h", flit_sel_ovc, eo); else passes++;
        checks++;
        if (last_tail >= 0) begin
          if (cyc - last_tail != 2) $display("FAIL alt_gap got=%0d exp=2", cyc - last_tail); else passes++;
          checks++;
        end
      end
      if (flit_valid === 1'b1 && flit_tail === 1'b1) last_tail = cyc;
      advance();
    end
    src_req = '0;
    if (exp_q.size() != 0 || ovc_q.size() != 0)
      $display("FAIL alt_done left gnt=%0d ovc=%0d exp 0 0", exp_q.size(), ovc_q.size());
    else passes++;
    checks++;
    run_packets(0, 0);
  endtask

  task automatic test_stall();
    do_reset();
    run_packets(8, 3);
    run_packets(8, 0);
    src_len = {NS{2'd1}};
    src_req = 4'b0001;
    sample();
    if (src_gnt !== 4'b0001) $display("FAIL stall_gnt got=%b exp=0001", src_gnt); else passes++;
    checks++;
    advance();
    src_req = '0;
    sample();
    if ({flit_valid, flit_head, flit_sel_ovc} !== {2'b11, 8'h01})
      $display("FAIL stall_first got=%b%b %h exp=11 01", flit_valid, flit_head, flit_sel_ovc);
    else passes++;
    checks++;
    advance();
    repeat (3) begin
      sample();
      if (flit_valid !== 1'b0 || busy !== 1'b1) $display("FAIL stall_hold valid=%b busy=%b exp 0 1", flit_valid, busy);
      else passes++;
      checks++;
      if (obs !== exp_vec) $display("FAIL stall_model got=%h exp=%h", obs, exp_vec); else passes++;
      checks++;
      advance();
    end
    for (int r = 0; r < 2; r++) begin
      flow_ctrl = {3'd0, 1'b1};
      sample();
      if (flit_valid !== 1'b0) $display("FAIL stall_bypass%0d valid=%b exp=0", r, flit_valid); else passes++;
      checks++;
      advance();
      flow_ctrl = '0;
      sample();
      if ({flit_valid, flit_head, flit_tail} !== {1'b1, 1'b0, r == 1})
        $display("FAIL stall_resume%0d got=%b%b%b exp=10%b", r, flit_valid, flit_head, flit_tail, r == 1);
      else passes++;
      checks++;
      advance();
    end
  endtask

  task automatic test_credit_boundary();
    do_reset();
    src_len = {NS{2'd0}};
    src_req = 4'b0001;
    sample(); advance();
    src_req = '0;
    flow_ctrl = {3'd0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      sample();
      if (obs !== exp_vec) $display("FAIL credit_model got=%h exp=%h", obs, exp_vec); else passes++;
      checks++;
      if (k >= 2) begin
        if (error !== 1'b0) $display("FAIL credit_err_early%0d got=%b exp=0", k, error); else passes++;
        checks++;
      end
      advance();
      flow_ctrl = (k == 1 || k == 2) ? {3'd0, 1'b1} : '0;
    end
    repeat (4) begin
      sample();
      if (error !== 1'b1) $display("FAIL credit_err_sticky got=%b exp=1", error); else passes++;
      checks++;
      advance();
    end
  endtask

  task automatic test_no_credit();
    do_reset();
    run_packets(8, 3);
    run_packets(8, 1);
    src_len = {NS{2'd0}};
    src_req = 4'b1111;
    repeat (6) begin
      sample();
      if (src_gnt !== 4'b0000 || flit_valid !== 1'b0)
        $display("FAIL nocred_idle gnt=%b valid=%b exp 0000 0", src_gnt, flit_valid);
      else passes++;
      checks++;
      advance();
    end
    flow_ctrl = {3'd5, 1'b1};
    sample();
    if (src_gnt !== 4'b0000) $display("FAIL nocred_bypass gnt=%b exp=0000", src_gnt); else passes++;
    checks++;
    advance();
    flow_ctrl = '0;
    sample();
    if (src_gnt !== 4'b0010) $display("FAIL nocred_gnt got=%b exp=0010", src_gnt); else passes++;
    checks++;
    advance();
    src_req = '0;
    sample();
    if ({flit_head, flit_sel_ovc, src_pop} !== {1'b1, 8'h20, 4'b0010})
      $display("FAIL nocred_head got=%b %h %b exp=1 20 0010", flit_head, flit_sel_ovc, src_pop);
    else passes++;
    checks++;
    advance();
  endtask

  task automatic test_reset_mid();
    do_reset();
    src_len = {NS{2'd3}};
    src_req = 4'b0001;
    sample(); advance();
    src_req = '0;
    repeat (2) begin
      sample();
      if (obs !== exp_vec) $display("FAIL rstmid_model got=%h exp=%h", obs, exp_vec); else passes++;
      checks++;
      advance();
    end
    reset = 1;
    sample(); advance();
    reset = 0;
    sample();
    if (obs !== 21'd0) $display("FAIL rstmid_outputs got=%h exp=0", obs); else passes++;
    checks++;
    advance();
    src_len = {NS{2'd0}};
    src_req = 4'b0010;
    sample();
    if (src_gnt !== 4'b0010) $display("FAIL rstmid_gnt got=%b exp=0010", src_gnt); else passes++;
    checks++;
    advance();
    src_req = '0;
    sample();
    if ({flit_valid, flit_head, flit_tail, flit_sel_ovc} !== {3'b110, 8'h01})
      $display("FAIL rstmid_head got=%b%b%b %h exp=110 01", flit_valid, flit_head, flit_tail, flit_sel_ovc);
    else passes++;
    checks++;
    advance();
    run_packets(0, 0);
  endtask

  task automatic test_random();
    logic [NS-1:0] nxt;
    int vc;
    do_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      sample();
      if (obs !== exp_vec) $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); else passes++;
      checks++;
      nxt = src_req & ~e_gnt;
      advance();
      for (int s = 0; s < NS; s++) begin
        if (!nxt[s] && $urandom_range(0, 2) == 0) begin
          nxt[s] = 1'b1;
          src_len[s*PLW +: PLW] = 2'($urandom_range(0, 3));
        end
      end
      src_req = nxt;
      vc = $urandom_range(0, NV - 1);
      flow_ctrl = ($urandom_range(0, 2) != 0 && m_cred[vc] < PER_VC) ? {3'(vc), 1'b1} : '0;
    end
    flow_ctrl = '0;
    src_req = '0;
`ifdef PIS_STATS_EN
    sample();
    if (flit_count !== m_flits || pkt_count !== m_pkts)
      $display("FAIL stats got=%0d/%0d exp=%0d/%0d", flit_count, pkt_count, m_flits, m_pkts);
    else passes++;
    checks++;
    advance();
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_packet();
    test_alternate();
    test_stall();
    test_credit_boundary();
    test_no_credit();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
